// File: rtl/newspaper_dispenser.sv
// rtl/newspaper_dispenser.sv - paper-feed dispenser with request queue and stock tracking
//
// Purpose: accepts one-cycle dispense requests, runs the feed motor for
// MOTOR_CYCLES cycles per copy, tracks pending requests and remaining stock.
// Optional feature macro: DISPENSE_COUNT_EN (adds saturating 16-bit `total`).
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   newspaper in   one-cycle dispense request
//   refill    in   one-cycle pulse, reloads stock to STOCK_INIT
//   motor     out  feed motor drive (registered)
//   done      out  one-cycle pulse, one copy delivered (registered)
//   refund    out  one-cycle pulse, request rejected (registered)
//   empty     out  stock == 0 (combinational)
//   pending   out  accepted but undelivered requests (registered)
//   stock     out  copies remaining (registered)
//   total     out  delivered-copy count, saturating (DISPENSE_COUNT_EN only)
module newspaper_dispenser #(
  parameter int MOTOR_CYCLES = 4,
  parameter int STOCK_INIT   = 8,
  parameter int STOCK_W      = 8,
  parameter int PEND_DEPTH   = 3,
  parameter int PEND_W       = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               newspaper,
  input  logic               refill,
  output logic               motor,
  output logic               done,
  output logic               refund,
  output logic               empty,
  output logic [PEND_W-1:0]  pending,
`ifdef DISPENSE_COUNT_EN
  output logic [15:0]        total,
`endif
  output logic [STOCK_W-1:0] stock
);

  localparam int TIMER_W = (MOTOR_CYCLES > 1) ? $clog2(MOTOR_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, GAP = 2'd2} state_t;

  state_t              state, state_d;
  logic [TIMER_W-1:0]  timer, timer_d;
  logic                accept;
  logic                deliver;
  logic [PEND_W-1:0]   pending_d;
  logic [STOCK_W-1:0]  stock_d;

  always_comb begin
    state_d   = state;
    timer_d   = timer;
    pending_d = pending;
    stock_d   = stock;

    // Judged on the current register values, before this edge's updates.
    accept  = newspaper &&
              (32'(pending) < PEND_DEPTH) &&
              (32'(pending) < 32'(stock));
    // Counters drop on the edge that enters GAP.
    deliver = (state == RUN) && (timer == '0);

    case (state)
      IDLE: begin
        if (pending != '0 && stock != '0) begin
          state_d = RUN;
          timer_d = TIMER_W'(MOTOR_CYCLES - 1);
        end
      end
      RUN: begin
        if (timer == '0) state_d = GAP;
        else             timer_d = timer - TIMER_W'(1);
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Simultaneous accept and delivery cancel out.
    if (accept && !deliver)      pending_d = pending + PEND_W'(1);
    else if (!accept && deliver) pending_d = pending - PEND_W'(1);

    // Refill wins over a coincident delivery decrement.
    if (refill)       stock_d = STOCK_W'(STOCK_INIT);
    else if (deliver) stock_d = stock - STOCK_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      motor   <= 1'b0;
      done    <= 1'b0;
      refund  <= 1'b0;
      pending <= '0;
      stock   <= STOCK_W'(STOCK_INIT);
    end else begin
      state   <= state_d;
      timer   <= timer_d;
      motor   <= (state_d == RUN);
      done    <= (state_d == GAP);
      refund  <= newspaper && !accept;
      pending <= pending_d;
      stock   <= stock_d;
    end
  end

`ifdef DISPENSE_COUNT_EN
  // Counts in step with the done pulse; refill does not touch it.
  always_ff @(posedge clk) begin
    if (rst)                                  total <= '0;
    else if (state_d == GAP && total != 16'hFFFF) total <= total + 16'd1;
  end
`endif

  assign empty = (stock == '0);

endmodule

// File: tb/tb_newspaper_dispenser.sv
// tb/tb_newspaper_dispenser.sv - scoreboard bench for newspaper_dispenser
module tb_newspaper_dispenser;

  localparam int MC    = 4;
  localparam int SI    = 8;
  localparam int DEPTH = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       newspaper = 1'b0;
  logic       refill = 1'b0;
  logic       motor, done, refund, empty;
  logic [1:0] pending;
  logic [7:0] stock;
`ifdef DISPENSE_COUNT_EN
  logic [15:0] total;
`endif

  newspaper_dispenser #(
    .MOTOR_CYCLES(MC), .STOCK_INIT(SI), .STOCK_W(8), .PEND_DEPTH(DEPTH), .PEND_W(2)
  ) dut (
    .clk(clk), .rst(rst), .newspaper(newspaper), .refill(refill),
    .motor(motor), .done(done), .refund(refund), .empty(empty),
    .pending(pending),
`ifdef DISPENSE_COUNT_EN
    .total(total),
`endif
    .stock(stock)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Scoreboard queues: cycle numbers in which a pulse is expected.
  int done_q[$];
  int refund_q[$];
  // Model: scheduled delivery cycles, pending count, stock, last delivery cycle.
  int sched[$];
  int m_pend, m_stock, m_last, m_t, m_total;
  bit m_valid = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT pulses done/refund.
  always @(negedge clk) begin
    if (m_valid) begin
      if (done) begin
        if (done_q.size() == 0) chk("done_unexpected", 1, 0);
        else chk("done_cycle", cyc, done_q.pop_front());
`ifdef DISPENSE_COUNT_EN
        if (m_total < 16'hFFFF) m_total++;
        chk("total", int'(total), m_total);
`endif
      end
      if (refund) begin
        if (refund_q.size() == 0) chk("refund_unexpected", 1, 0);
        else chk("refund_cycle", cyc, refund_q.pop_front());
      end
      if (done_q.size() > 0 && done_q[0] < cyc) chk("done_missed", cyc, done_q.pop_front());
      if (refund_q.size() > 0 && refund_q[0] < cyc) chk("refund_missed", cyc, refund_q.pop_front());
    end
  end

  task automatic step(input bit np, input bit rf, input bit r);
    int  t;
    bit  m_motor;
    bit  dec;
    @(negedge clk);
    t   = cyc;
    m_t = t;
    while (sched.size() > 0 && sched[0] < t - 1) void'(sched.pop_front());
    if (m_valid) begin
      m_motor = 1'b0;
      foreach (sched[i]) if (sched[i] - MC <= t && t < sched[i]) m_motor = 1'b1;
      chk("stock", int'(stock), m_stock);
      chk("pending", int'(pending), m_pend);
      chk("empty", int'(empty), int'(m_stock == 0));
      chk("motor", int'(motor), int'(m_motor));
    end
    newspaper = np;
    refill    = rf;
    rst       = r;
    if (r) begin
      m_pend  = 0;
      m_stock = SI;
      m_last  = -100;
    end else if (m_valid) begin
      if (np && m_pend < DEPTH && m_pend < m_stock) begin
        // A copy completes MC+2 cycles after both it and the previous copy are ready.
        m_last = ((t > m_last) ? t : m_last) + MC + 2;
        done_q.push_back(m_last);
        sched.push_back(m_last);
        m_pend++;
      end else if (np) begin
        refund_q.push_back(t + 1);
      end
      dec = 1'b0;
      foreach (sched[i]) if (sched[i] == t + 1) dec = 1'b1;
      if (dec) m_pend--;
      if (rf)       m_stock = SI;
      else if (dec) m_stock--;
    end
    @(posedge clk);
    if (r) begin
      done_q.delete();
      refund_q.delete();
      sched.delete();
      m_total = 0;
      m_valid = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  initial begin
    int d1;
    int guard;
    step(0, 0, 1);
    step(0, 0, 1);

    // Single request: latency and counter updates.
    step(1, 0, 0);
    idle(10);

    // Four consecutive requests: fourth refunded.
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    idle(25);

    // Drain stock to zero, then a request must be refunded.
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0);
      idle(7);
    end
    chk("empty_after_drain", int'(empty), 1);
    step(1, 0, 0);
    idle(3);
    step(0, 1, 0);
    idle(2);

    // Deliver 5 (stock 3), then refill in the cycle before the GAP decrement.
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0);
      idle(7);
    end
    step(1, 0, 0);
    guard = 0;
    while (m_t + 1 != m_last - 1 && guard < 60) begin
      step(0, 0, 0);
      guard++;
    end
    step(0, 1, 0);
    idle(5);
    chk("stock_refill_at_gap", int'(stock), SI);

    // Reset in the second motor cycle with two pending.
    step(1, 0, 0);
    step(1, 0, 0);
    d1 = m_last - (MC + 2);
    guard = 0;
    while (m_t + 1 != d1 - MC + 1 && guard < 60) begin
      step(0, 0, 0);
      guard++;
    end
    chk("pending_before_reset", int'(pending), 2);
    step(0, 0, 1);
    idle(15);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom % 3) == 0, ($urandom % 40) == 0, ($urandom % 500) == 0);
    end
    idle(30);
    chk("done_q_drained", done_q.size(), 0);
    chk("refund_q_drained", refund_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
